// File: rtl/inst_encoder_pkg.sv
// Shared RV32I encoder definitions: opcodes, error codes, FSM states.
// The opcode constants are also used by the core decoder and sign-extend path.
package inst_encoder_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'b00,
    ERR_RANGE = 2'b01,
    ERR_ALIGN = 2'b10,
    ERR_OPC   = 2'b11
  } err_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WRITE = 2'b01,
    FULL  = 2'b10
  } state_e;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
  } fields_t;

endpackage

// File: rtl/inst_encoder_pack.sv
// Combinational RV32I field packer with immediate legality check.
// Error priority: unsupported opcode, then range, then branch alignment.
module inst_pack
  import inst_encoder_pkg::*;
#(
  parameter int WORD = 32
) (
  input  fields_t         f_i,
  output logic [WORD-1:0] word_o,
  output logic            err_o,
  output err_e            code_o
);

  logic        imm12_ok;
  logic        br_ok;
  logic [31:0] im;

  assign im       = f_i.imm;
  assign imm12_ok = ($signed(im) >= -32'sd2048) &&
                    ($signed(im) <= 32'sd2047);
  assign br_ok    = ($signed(im) >= -32'sd4096) &&
                    ($signed(im) <= 32'sd4094);

  always_comb begin
    word_o = '0;
    code_o = ERR_NONE;
    unique case (1'b1)
      (f_i.opcode == OP_R): begin
        word_o = {f_i.funct7, f_i.rs2, f_i.rs1,
                  f_i.funct3, f_i.rd, f_i.opcode};
      end
      (f_i.opcode == OP_IMM),
      (f_i.opcode == OP_LOAD): begin
        if (!imm12_ok) code_o = ERR_RANGE;
        word_o = {im[11:0], f_i.rs1, f_i.funct3,
                  f_i.rd, f_i.opcode};
      end
      (f_i.opcode == OP_STORE): begin
        if (!imm12_ok) code_o = ERR_RANGE;
        word_o = {im[11:5], f_i.rs2, f_i.rs1,
                  f_i.funct3, im[4:0], f_i.opcode};
      end
      (f_i.opcode == OP_BRANCH): begin
        if (!br_ok) code_o = ERR_RANGE;
        else if (im[0]) code_o = ERR_ALIGN;
        word_o = {im[12], im[10:5], f_i.rs2, f_i.rs1,
                  f_i.funct3, im[4:1], im[11], f_i.opcode};
      end
      default: code_o = ERR_OPC;
    endcase
  end

  assign err_o = (code_o != ERR_NONE);

endmodule

// File: rtl/inst_encoder.sv
// Program-loader instruction encoder: handshake in, packed RV32I words
// written sequentially to instruction memory through a stallable port.
module inst_encoder
  import inst_encoder_pkg::*;
#(
  parameter int WORD   = 32,
  parameter int OPCODE = 7,
  parameter int ADDR   = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              enc_valid_i,
  output logic              enc_ready_o,
  input  logic [OPCODE-1:0] opcode_i,
  input  logic [4:0]        rd_i,
  input  logic [4:0]        rs1_i,
  input  logic [4:0]        rs2_i,
  input  logic [2:0]        funct3_i,
  input  logic [6:0]        funct7_i,
  input  logic [31:0]       imm_i,
  input  logic              addr_clr_i,
  output logic              wr_en_o,
  input  logic              wr_ready_i,
  output logic [ADDR-1:0]   wr_addr_o,
  output logic [WORD-1:0]   wr_data_o,
  output logic              err_o,
  output logic [1:0]        err_code_o,
  output logic              full_o
);

  fields_t         f;
  logic [WORD-1:0] pk_word;
  logic            pk_err;
  err_e            pk_code;

  state_e          state_q, state_d;
  logic [ADDR-1:0] addr_q, addr_d;
  logic [WORD-1:0] data_q, data_d;
  logic            err_q, err_d;
  err_e            code_q, code_d;

  logic last;
  logic accept;
  logic take;

  assign f = '{opcode: opcode_i, rd: rd_i, rs1: rs1_i,
               rs2: rs2_i, funct3: funct3_i,
               funct7: funct7_i, imm: imm_i};

  inst_pack #(.WORD(WORD)) u_pack (
    .f_i    (f),
    .word_o (pk_word),
    .err_o  (pk_err),
    .code_o (pk_code)
  );

  assign last = &addr_q;

  // Never accept a bundle on the cycle that lands in FULL or clears.
  assign enc_ready_o = !addr_clr_i &&
    ((state_q == IDLE) ||
     (state_q == WRITE && wr_ready_i && !last));

  assign accept = enc_valid_i && enc_ready_o;
  assign take   = accept && !pk_err;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    err_d   = accept && pk_err;
    code_d  = (accept && pk_err) ? pk_code : code_q;
    if (addr_clr_i) begin
      state_d = IDLE;
      addr_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (take) begin
            state_d = WRITE;
            data_d  = pk_word;
          end
        end
        WRITE: begin
          if (wr_ready_i) begin
            if (last) begin
              state_d = FULL;
            end else begin
              addr_d = addr_q + 1'b1;
              if (take) data_d = pk_word;
              else state_d = IDLE;
            end
          end
        end
        FULL: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      code_q  <= ERR_NONE;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  assign wr_en_o    = (state_q == WRITE);
  assign full_o     = (state_q == FULL);
  assign wr_addr_o  = addr_q;
  assign wr_data_o  = data_q;
  assign err_o      = err_q;
  assign err_code_o = code_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder with a 4-entry memory (ADDR=2).
// Each task drives one scenario and checks against hand-computed values.
module tb_inst_encoder;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        enc_valid_i;
  logic        enc_ready_o;
  logic [6:0]  opcode_i;
  logic [4:0]  rd_i, rs1_i, rs2_i;
  logic [2:0]  funct3_i;
  logic [6:0]  funct7_i;
  logic [31:0] imm_i;
  logic        addr_clr_i;
  logic        wr_en_o;
  logic        wr_ready_i;
  logic [1:0]  wr_addr_o;
  logic [31:0] wr_data_o;
  logic        err_o;
  logic [1:0]  err_code_o;
  logic        full_o;

  int ncmp = 0;
  int nerr = 0;

  inst_encoder #(.WORD(32), .OPCODE(7), .ADDR(2)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .enc_valid_i (enc_valid_i),
    .enc_ready_o (enc_ready_o),
    .opcode_i    (opcode_i),
    .rd_i        (rd_i),
    .rs1_i       (rs1_i),
    .rs2_i       (rs2_i),
    .funct3_i    (funct3_i),
    .funct7_i    (funct7_i),
    .imm_i       (imm_i),
    .addr_clr_i  (addr_clr_i),
    .wr_en_o     (wr_en_o),
    .wr_ready_i  (wr_ready_i),
    .wr_addr_o   (wr_addr_o),
    .wr_data_o   (wr_data_o),
    .err_o       (err_o),
    .err_code_o  (err_code_o),
    .full_o      (full_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_b(input logic [6:0] op, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] imm);
    opcode_i = op; rd_i = rd; rs1_i = rs1; rs2_i = rs2;
    funct3_i = f3; funct7_i = f7; imm_i = imm;
  endtask

  task automatic test_reset;
    rst_ni = 1'b0;
    tick;
    tick;
    ncmp++; if (wr_en_o !== 1'b0) begin nerr++; $display("FAIL rst_wr_en got %b want 0", wr_en_o); end
    ncmp++; if (wr_addr_o !== 2'd0) begin nerr++; $display("FAIL rst_addr got %0d want 0", wr_addr_o); end
    ncmp++; if (wr_data_o !== 32'h0) begin nerr++; $display("FAIL rst_data got %h want 0", wr_data_o); end
    ncmp++; if (err_o !== 1'b0) begin nerr++; $display("FAIL rst_err got %b want 0", err_o); end
    ncmp++; if (err_code_o !== 2'b00) begin nerr++; $display("FAIL rst_code got %b want 00", err_code_o); end
    ncmp++; if (full_o !== 1'b0) begin nerr++; $display("FAIL rst_full got %b want 0", full_o); end
    ncmp++; if (enc_ready_o !== 1'b1) begin nerr++; $display("FAIL rst_ready got %b want 1", enc_ready_o); end
    rst_ni = 1'b1;
    tick;
  endtask

  task automatic test_back_to_back;
    set_b(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    enc_valid_i = 1'b1;
    @(negedge clk_i);
    ncmp++; if (enc_ready_o !== 1'b1) begin nerr++; $display("FAIL b2b_ready0 got %b want 1", enc_ready_o); end
    tick;
    ncmp++; if (wr_en_o !== 1'b1) begin nerr++; $display("FAIL addi_wr_en got %b want 1", wr_en_o); end
    ncmp++; if (wr_addr_o !== 2'd0) begin nerr++; $display("FAIL addi_addr got %0d want 0", wr_addr_o); end
    ncmp++; if (wr_data_o !== 32'h00500093) begin nerr++; $display("FAIL addi_data got %h want 00500093", wr_data_o); end
    set_b(7'b0100011, 5'd0, 5'd1, 5'd2, 3'b010, 7'd0, 32'd8);
    @(negedge clk_i);
    ncmp++; if (enc_ready_o !== 1'b1) begin nerr++; $display("FAIL b2b_ready1 got %b want 1", enc_ready_o); end
    tick;
    ncmp++; if (wr_en_o !== 1'b1) begin nerr++; $display("FAIL sw_wr_en got %b want 1", wr_en_o); end
    ncmp++; if (wr_addr_o !== 2'd1) begin nerr++; $display("FAIL sw_addr got %0d want 1", wr_addr_o); end
    ncmp++; if (wr_data_o !== 32'h0020A423) begin nerr++; $display("FAIL sw_data got %h want 0020a423", wr_data_o); end
    enc_valid_i = 1'b0;
    tick;
    ncmp++; if (wr_en_o !== 1'b0) begin nerr++; $display("FAIL b2b_idle_wr_en got %b want 0", wr_en_o); end
    ncmp++; if (wr_addr_o !== 2'd2) begin nerr++; $display("FAIL b2b_addr got %0d want 2", wr_addr_o); end
  endtask

  task automatic test_errors;
    logic [6:0]  ops  [4] = '{7'b0010011, 7'b1100011, 7'b1111111, 7'b1100011};
    logic [31:0] imms [4] = '{32'd2048, 32'd3, 32'd0, 32'd4095};
    logic [1:0]  codes[4] = '{2'b01, 2'b10, 2'b11, 2'b01};
    for (int i = 0; i < 4; i++) begin
      set_b(ops[i], 5'd1, 5'd1, 5'd2, 3'd0, 7'd0, imms[i]);
      enc_valid_i = 1'b1;
      tick;
      enc_valid_i = 1'b0;
      ncmp++; if (err_o !== 1'b1) begin nerr++; $display("FAIL err%0d_pulse got %b want 1", i, err_o); end
      ncmp++; if (err_code_o !== codes[i]) begin nerr++; $display("FAIL err%0d_code got %b want %b", i, err_code_o, codes[i]); end
      ncmp++; if (wr_en_o !== 1'b0) begin nerr++; $display("FAIL err%0d_wr_en got %b want 0", i, wr_en_o); end
      ncmp++; if (wr_addr_o !== 2'd2) begin nerr++; $display("FAIL err%0d_addr got %0d want 2", i, wr_addr_o); end
      tick;
      ncmp++; if (err_o !== 1'b0) begin nerr++; $display("FAIL err%0d_one_cycle got %b want 0", i, err_o); end
      ncmp++; if (err_code_o !== codes[i]) begin nerr++; $display("FAIL err%0d_hold got %b want %b", i, err_code_o, codes[i]); end
    end
  endtask

  task automatic test_stall_branch;
    wr_ready_i = 1'b0;
    set_b(7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, -32'sd4);
    enc_valid_i = 1'b1;
    tick;
    set_b(7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'd0);
    ncmp++; if (wr_data_o !== 32'hFE208EE3) begin nerr++; $display("FAIL beq_data got %h want fe208ee3", wr_data_o); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      ncmp++; if (enc_ready_o !== 1'b0) begin nerr++; $display("FAIL stall%0d_ready got %b want 0", c, enc_ready_o); end
      tick;
      ncmp++; if (wr_en_o !== 1'b1) begin nerr++; $display("FAIL stall%0d_wr_en got %b want 1", c, wr_en_o); end
      ncmp++; if (wr_addr_o !== 2'd2) begin nerr++; $display("FAIL stall%0d_addr got %0d want 2", c, wr_addr_o); end
      ncmp++; if (wr_data_o !== 32'hFE208EE3) begin nerr++; $display("FAIL stall%0d_data got %h want fe208ee3", c, wr_data_o); end
    end
    wr_ready_i = 1'b1;
    @(negedge clk_i);
    ncmp++; if (enc_ready_o !== 1'b1) begin nerr++; $display("FAIL unstall_ready got %b want 1", enc_ready_o); end
    tick;
    enc_valid_i = 1'b0;
    ncmp++; if (wr_addr_o !== 2'd3) begin nerr++; $display("FAIL sub_addr got %0d want 3", wr_addr_o); end
    ncmp++; if (wr_data_o !== 32'h402081B3) begin nerr++; $display("FAIL sub_data got %h want 402081b3", wr_data_o); end
    ncmp++; if (wr_en_o !== 1'b1) begin nerr++; $display("FAIL sub_wr_en got %b want 1", wr_en_o); end
    @(negedge clk_i);
    ncmp++; if (enc_ready_o !== 1'b0) begin nerr++; $display("FAIL last_ready got %b want 0", enc_ready_o); end
  endtask

  task automatic test_full_clear;
    tick;
    ncmp++; if (full_o !== 1'b1) begin nerr++; $display("FAIL full got %b want 1", full_o); end
    ncmp++; if (wr_en_o !== 1'b0) begin nerr++; $display("FAIL full_wr_en got %b want 0", wr_en_o); end
    set_b(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    enc_valid_i = 1'b1;
    @(negedge clk_i);
    ncmp++; if (enc_ready_o !== 1'b0) begin nerr++; $display("FAIL full_ready got %b want 0", enc_ready_o); end
    addr_clr_i = 1'b1;
    @(negedge clk_i);
    ncmp++; if (enc_ready_o !== 1'b0) begin nerr++; $display("FAIL clr_ready got %b want 0", enc_ready_o); end
    tick;
    addr_clr_i = 1'b0;
    ncmp++; if (full_o !== 1'b0) begin nerr++; $display("FAIL clr_full got %b want 0", full_o); end
    ncmp++; if (wr_addr_o !== 2'd0) begin nerr++; $display("FAIL clr_addr got %0d want 0", wr_addr_o); end
    ncmp++; if (wr_en_o !== 1'b0) begin nerr++; $display("FAIL clr_no_accept got %b want 0", wr_en_o); end
    tick;
    enc_valid_i = 1'b0;
    ncmp++; if (wr_en_o !== 1'b1) begin nerr++; $display("FAIL post_clr_wr_en got %b want 1", wr_en_o); end
    ncmp++; if (wr_addr_o !== 2'd0) begin nerr++; $display("FAIL post_clr_addr got %0d want 0", wr_addr_o); end
    ncmp++; if (wr_data_o !== 32'h00500093) begin nerr++; $display("FAIL post_clr_data got %h want 00500093", wr_data_o); end
  endtask

  task automatic test_reset_mid_write;
    wr_ready_i = 1'b0;
    tick;
    ncmp++; if (wr_en_o !== 1'b1) begin nerr++; $display("FAIL pend_wr_en got %b want 1", wr_en_o); end
    #1 rst_ni = 1'b0;
    #1;
    ncmp++; if (wr_en_o !== 1'b0) begin nerr++; $display("FAIL async_rst_wr_en got %b want 0", wr_en_o); end
    tick;
    rst_ni = 1'b1;
    tick;
    ncmp++; if (wr_en_o !== 1'b0) begin nerr++; $display("FAIL rel_wr_en got %b want 0", wr_en_o); end
    ncmp++; if (wr_addr_o !== 2'd0) begin nerr++; $display("FAIL rel_addr got %0d want 0", wr_addr_o); end
    ncmp++; if (wr_data_o !== 32'h0) begin nerr++; $display("FAIL rel_data got %h want 0", wr_data_o); end
    ncmp++; if (err_code_o !== 2'b00) begin nerr++; $display("FAIL rel_code got %b want 00", err_code_o); end
    ncmp++; if (full_o !== 1'b0) begin nerr++; $display("FAIL rel_full got %b want 0", full_o); end
    ncmp++; if (enc_ready_o !== 1'b1) begin nerr++; $display("FAIL rel_ready got %b want 1", enc_ready_o); end
  endtask

  initial begin
    enc_valid_i = 1'b0;
    addr_clr_i  = 1'b0;
    wr_ready_i  = 1'b1;
    set_b(7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    test_reset;
    test_back_to_back;
    test_errors;
    test_stall_branch;
    test_full_clear;
    test_reset_mid_write;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/inst_encoder.md
# inst_encoder

Instruction encoder for the single-cycle core's FPGA program loader. It accepts decoded instruction fields (opcode, registers, funct, signed immediate) over a valid/ready handshake, range-checks the immediate, and packs the fields into a 32-bit RV32I word. It writes the packed words sequentially into instruction memory through a stallable write port. It is the inverse of the core's immediate sign-extension path.

## Interface
Parameters:
- WORD, 32, instruction/data width
- OPCODE, 7, opcode field width
- ADDR, 8, instruction-memory word-address width (depth 2^ADDR)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- enc_valid_i  in  1  field bundle valid
- enc_ready_o  out  1  encoder can accept bundle
- opcode_i  in  7  opcode
- rd_i / rs1_i / rs2_i  in  5 each  register indices
- funct3_i  in  3  funct3
- funct7_i  in  7  funct7 (R-type only)
- imm_i  in  32  signed immediate, byte offset for branches
- addr_clr_i  in  1  synchronous clear of write address and FULL state
- wr_en_o  out  1  memory write request
- wr_ready_i  in  1  memory accepts write this cycle
- wr_addr_o  out  ADDR  word address
- wr_data_o  out  WORD  encoded instruction
- err_o  out  1  one-cycle pulse: bundle rejected
- err_code_o  out  2  01 imm range, 10 branch misaligned, 11 unsupported opcode (held until next error)
- full_o  out  1  last address written

## Operation
Encoding is decided by opcode:
- 0110011 R: {funct7, rs2, rs1, funct3, rd, op}; imm ignored
- 0010011 / 0000011 I/load: {imm[11:0], rs1, funct3, rd, op}; requires −2048 ≤ imm ≤ 2047
- 0100011 S: {imm[11:5], rs2, rs1, funct3, imm[4:0], op}; same range
- 1100011 B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op}; requires −4096 ≤ imm ≤ 4094 and imm[0]=0
- Any other opcode: error 11.
- Error priority: opcode, then range, then alignment.

A rejected bundle is consumed: it is handshaken, err_o pulses, and no write occurs. The address does not advance.

State machine:
- IDLE: no pending write. A valid, legal accepted bundle → WRITE.
- WRITE: wr_en_o=1 with registered addr/data.
  - On wr_ready_i, the address increments.
  - If the written address was 2^ADDR−1 → FULL.
  - Else, if a new legal bundle is accepted in the same cycle → stay in WRITE.
  - Else → IDLE.
- FULL: enc_ready_o=0, wr_en_o=0. addr_clr_i → IDLE with address 0.

Handshake and clear rules:
- enc_ready_o = (state==IDLE) | (state==WRITE & wr_ready_i), with the state not about to become FULL.
- addr_clr_i in WRITE abandons the pending write: next state is IDLE, address 0.
- addr_clr_i has priority over any simultaneous accept; the bundle is not accepted (enc_ready_o=0 while addr_clr_i=1).
- The address never wraps silently; FULL is terminal until cleared.

## Timing
- Reset values: state IDLE, wr_en_o 0, wr_addr_o 0, wr_data_o 0, err_o 0, err_code_o 00, full_o 0, enc_ready_o 1.
- Latency: a bundle accepted at edge N gives wr_en_o/wr_data_o valid after edge N; the earliest write completes at edge N+1.
- Throughput is one instruction per cycle while wr_ready_i=1.
- wr_addr_o, wr_data_o and wr_en_o hold stable while wr_en_o=1 & wr_ready_i=0.
- err_o asserts in the cycle after the rejected handshake, for one cycle.
- Reset asserted mid-WRITE drops wr_en_o immediately (asynchronously); the pending write is lost.

## Structure
- Shared package holds:
  - opcode constants OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH
  - error codes ERR_RANGE, ERR_ALIGN, ERR_OPC
  - state enum IDLE/WRITE/FULL
- The same opcode constants are reused by the core's decoder and sign-extension logic.
- One combinational sub-module, inst_pack, contains the field packing and legality check. The top level holds the FSM, the output register and the address counter.

## Test plan
- Encode addi x1,x0,5 (op 0010011, rd 1, rs1 0, f3 0, imm 5) → wr_data_o 0x00500093 at address 0. Then sw x2,8(x1) (rs2 2, rs1 1, f3 010, imm 8) → 0x0020A423 at address 1, back-to-back.
- Encode beq x1,x2,-4 → 0xFE208EE3.
- Error checks, each with no write and the address unchanged:
  - addi with imm 2048 → err 01
  - beq with imm 3 → err 10
  - opcode 1111111 → err 11
- Hold wr_ready_i=0 for 3 cycles during a write → wr_addr_o/wr_data_o stable and enc_ready_o=0. The write completes on the cycle wr_ready_i rises.
- With ADDR=2, write 4 instructions → full_o=1 and enc_ready_o=0. addr_clr_i → next write goes to address 0.
- Assert rst_ni low while wr_en_o=1 → wr_en_o drops without waiting for a clock edge. After release, all outputs are at their reset values.
